cmd_decoder: RTL and testbench
==============================

# cmd_decoder

Byte-level command decoder between the SPI subordinate's RX/TX byte streams and the rendering pipeline. Frames the incoming byte stream into opcode-plus-payload commands and emits each as one wide packet on a valid/ready interface. Handles control opcodes locally: reset request, ping, and status readback. Drops malformed or stalled commands, recording sticky error flags.

## Interface
- MAX_PAYLOAD_BYTES, 18, width of the payload bus in bytes; largest payload of any opcode
- TIMEOUT_CYCLES, 4096, idle cycles allowed between payload bytes before the command is aborted
- clk_system  in  1  system clock
- rstn_system  in  1  asynchronous active-low reset
- in_valid  in  1  RX byte valid, from the SPI subordinate
- in_ready  out  1  decoder accepts the RX byte this cycle
- in_data  in  8  RX byte
- pkt_valid  out  1  command packet valid, to the pipeline
- pkt_ready  in  1  pipeline accepts the packet
- pkt_opcode  out  8  opcode of the packet
- pkt_payload  out  8*MAX_PAYLOAD_BYTES  payload; byte k occupies [8k+7:8k]; bytes not carried by the opcode are 0
- tx_valid  out  1  reply byte valid, to the SPI subordinate
- tx_ready  in  1  SPI TX accepts the reply byte
- tx_data  out  8  reply byte
- cmd_reset  out  1  one-cycle reset request pulse
- err_flags  out  2  sticky flags: {err_timeout, err_unknown}

## Operation
- Opcode table, giving payload bytes and action:
  - 0x00 NOP: 0 bytes; no output.
  - 0x01 RESET: 0 bytes; cmd_reset pulses for one cycle.
  - 0x02 PING: 0 bytes; reply 0xA5.
  - 0x03 STATUS: 0 bytes; reply {6'b0, err_timeout, err_unknown}; both flags clear on the tx handshake.
  - 0x10 TRIANGLE: 18 bytes; emit packet.
  - 0x20 BEGIN_FRAME: 0 bytes; emit packet.
  - 0x21 END_FRAME: 0 bytes; emit packet.
  - Any other opcode: dropped; err_unknown set; state remains IDLE.
- States and transitions:
  - IDLE: in_ready=1. The accepted byte is the opcode.
    - Opcode with payload goes to PAYLOAD.
    - Zero-payload emit opcode goes to EMIT.
    - PING and STATUS go to REPLY.
    - NOP, RESET and unknown opcodes stay in IDLE.
  - PAYLOAD: in_ready=1. Each accepted byte is stored at index byte_cnt, then byte_cnt increments.
    - Last byte (byte_cnt = len-1) goes to EMIT.
    - Timeout goes to IDLE.
  - EMIT: in_ready=0, pkt_valid=1. On the pkt_valid && pkt_ready handshake, go to IDLE.
  - REPLY: in_ready=0, tx_valid=1. On the tx_valid && tx_ready handshake, go to IDLE.
- Timeout counter:
  - Clears on entry to PAYLOAD and on every accepted payload byte.
  - Increments on other PAYLOAD cycles.
  - Reaching TIMEOUT_CYCLES-1: partial payload discarded, err_timeout set, byte_cnt cleared, state goes to IDLE.
- Payload register is cleared to 0 when a new opcode is accepted, so unused bytes are always 0.
- pkt_opcode and pkt_payload are stable while pkt_valid=1. tx_data is stable while tx_valid=1.
- Error flags are only set in IDLE/PAYLOAD and only cleared in REPLY, so set and clear never coincide.
- RESET has no local effect beyond the pulse; the decoder continues decoding the following bytes.

## Timing
- Reset values:
  - State IDLE, in_ready=1.
  - pkt_valid=0, pkt_opcode=0, pkt_payload=0.
  - tx_valid=0, tx_data=0.
  - cmd_reset=0, err_flags=0, counters 0.
- Reset is asynchronous and may arrive mid-command. Any partial payload, pending packet or pending reply is lost without error.
- Byte accepted at cycle N means in_valid && in_ready at the rising edge N.
- Latency:
  - Opcode or last payload byte accepted at N: pkt_valid or tx_valid is high from N+1.
  - RESET accepted at N: cmd_reset is high during cycle N+1 only.
  - Unknown opcode accepted at N: err_unknown is high from N+1.
- Handshake at cycle M: the valid output is low at M+1, and in_ready is high at M+1.
- Throughput:
  - Back-to-back bytes are accepted at 1/cycle in IDLE and PAYLOAD.
  - A TRIANGLE takes at least 19 input cycles + 1 emit cycle.
- in_ready depends only on state, never combinationally on in_valid or pkt_ready.

## Test plan
- Send 0x10 then bytes 0x01..0x12, with pkt_ready=1: one packet, pkt_opcode=0x10, payload byte k = k+1, pkt_valid high for exactly 1 cycle.
- Send 0x20 with pkt_ready held 0 for 10 cycles, then send 0x21: in_ready=0 while 0x20 is pending, outputs stable; after 0x20 is taken, 0x21 yields a second packet with payload=0.
- Send 0x10 and 5 payload bytes, then stall for TIMEOUT_CYCLES: no packet, err_flags=2'b10. A following 0x20 emits normally.
- Send 0x7F, then 0x03 with tx_ready=1: err_flags=2'b01, then reply 0x01, then err_flags=0. A second 0x03 replies 0x00.
- Send 0x02 then 0x01: tx_data=0xA5 once, then cmd_reset high for exactly 1 cycle, with no pkt_valid.
- Assert rstn_system=0 after 0x10 and 7 payload bytes: all outputs at reset values. After release, a full TRIANGLE decodes correctly.

Source files
------------

// File: rtl/cmd_decoder.sv
// Command decoder: frames the SPI RX byte stream into opcode+payload packets,
// answers PING/STATUS on the TX byte stream and raises sticky error flags.
module cmd_decoder #(
  parameter int MAX_PAYLOAD_BYTES = 18,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                           clk_system,
  input  logic                           rstn_system,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_data,
  output logic                           pkt_valid,
  input  logic                           pkt_ready,
  output logic [7:0]                     pkt_opcode,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] pkt_payload,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_data,
  output logic                           cmd_reset,
  output logic [1:0]                     err_flags,
  output logic [1:0]                     dbg_state
);

  // All three streams are valid/ready: a transfer happens on the rising edge
  // where both are high; a raised valid holds with stable data until then, and
  // no ready here depends combinationally on the partner's valid.

  localparam int PW = 8 * MAX_PAYLOAD_BYTES;
  localparam int CW = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_RESET       = 8'h01;
  localparam logic [7:0] OP_PING        = 8'h02;
  localparam logic [7:0] OP_STATUS      = 8'h03;
  localparam logic [7:0] OP_TRIANGLE    = 8'h10;
  localparam logic [7:0] OP_BEGIN_FRAME = 8'h20;
  localparam logic [7:0] OP_END_FRAME   = 8'h21;
  localparam logic [7:0] PING_REPLY     = 8'hA5;

  localparam logic [CW-1:0] TRI_LAST = CW'(MAX_PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_EMIT    = 2'd2,
    S_REPLY   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   byte_cnt_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      opcode_q;
  logic [PW-1:0]   payload_q;
  logic [7:0]      tx_data_q;
  logic            cmd_reset_q;
  logic            err_timeout_q;
  logic            err_unknown_q;
  logic            last_byte;
  logic            timeout_hit;

  // in_ready is always 1 in PAYLOAD, so in_valid alone marks an accepted byte.
  assign last_byte   = (state_q == S_PAYLOAD) && in_valid && (byte_cnt_q == TRI_LAST);
  assign timeout_hit = (state_q == S_PAYLOAD) && !in_valid && (tmo_q == TMO_LAST);

  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    pkt_valid = 1'b0;
    tx_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (in_data)
            OP_TRIANGLE:                  state_d = S_PAYLOAD;
            OP_BEGIN_FRAME, OP_END_FRAME: state_d = S_EMIT;
            OP_PING, OP_STATUS:           state_d = S_REPLY;
            default:                      state_d = S_IDLE;
          endcase
        end
      end
      S_PAYLOAD: begin
        in_ready = 1'b1;
        if (last_byte)        state_d = S_EMIT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_EMIT: begin
        pkt_valid = 1'b1;
        if (pkt_ready) state_d = S_IDLE;
      end
      S_REPLY: begin
        tx_valid = 1'b1;
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      byte_cnt_q    <= '0;
      tmo_q         <= '0;
      opcode_q      <= '0;
      payload_q     <= '0;
      tx_data_q     <= '0;
      cmd_reset_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_unknown_q <= 1'b0;
    end else begin
      cmd_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            // Clearing here keeps bytes an opcode does not carry at zero.
            opcode_q   <= in_data;
            payload_q  <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            case (in_data)
              OP_NOP:                                    ;
              OP_RESET:                                  cmd_reset_q <= 1'b1;
              OP_PING:                                   tx_data_q <= PING_REPLY;
              OP_STATUS:                                 tx_data_q <= {6'b0, err_timeout_q, err_unknown_q};
              OP_TRIANGLE, OP_BEGIN_FRAME, OP_END_FRAME: ;
              default:                                   err_unknown_q <= 1'b1;
            endcase
          end
        end
        S_PAYLOAD: begin
          if (in_valid && in_ready) begin
            for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
              if (byte_cnt_q == CW'(k)) payload_q[8*k +: 8] <= in_data;
            end
            byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
            tmo_q      <= '0;
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            byte_cnt_q    <= '0;
            tmo_q         <= '0;
            payload_q     <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_REPLY: begin
          if (tx_ready) begin
            err_timeout_q <= 1'b0;
            err_unknown_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pkt_opcode  = opcode_q;
  assign pkt_payload = payload_q;
  assign tx_data     = tx_data_q;
  assign cmd_reset   = cmd_reset_q;
  assign err_flags   = {err_timeout_q, err_unknown_q};
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: directed scenarios plus random command traffic,
// checked every cycle against a transaction-level model of the decoder.
module tb_cmd_decoder;

  localparam int NB = 18;
  localparam int T  = 4096;
  localparam int PW = 8 * NB;

  // ---------------- clock / reset ----------------
  logic          clk_system  = 1'b0;
  logic          rstn_system = 1'b1;
  logic          in_valid    = 1'b0;
  logic [7:0]    in_data     = 8'h00;
  logic          pkt_ready   = 1'b0;
  logic          tx_ready    = 1'b0;
  logic          in_ready;
  logic          pkt_valid;
  logic [7:0]    pkt_opcode;
  logic [PW-1:0] pkt_payload;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          cmd_reset;
  logic [1:0]    err_flags;
  logic [1:0]    dbg_state;

  always #5 clk_system = ~clk_system;

  cmd_decoder #(.MAX_PAYLOAD_BYTES(NB), .TIMEOUT_CYCLES(T)) dut (
    .clk_system  (clk_system),
    .rstn_system (rstn_system),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_opcode  (pkt_opcode),
    .pkt_payload (pkt_payload),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .cmd_reset   (cmd_reset),
    .err_flags   (err_flags),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks pending packet / pending reply / payload collection as transactions.
  bit            m_pkt_pend = 0;
  bit            m_tx_pend  = 0;
  bit            m_collect  = 0;
  bit            m_rst      = 0;
  bit            m_err_t    = 0;
  bit            m_err_u    = 0;
  bit            m_acc;
  int            m_gap      = 0;
  logic [7:0]    m_bytes[$];
  logic [7:0]    m_pkt_op   = 8'h00;
  logic [PW-1:0] m_pkt_pay  = '0;
  logic [7:0]    m_tx_byte  = 8'h00;

  always @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      m_pkt_pend = 0; m_tx_pend = 0; m_collect = 0; m_rst = 0;
      m_err_t = 0; m_err_u = 0; m_gap = 0; m_bytes.delete();
    end else begin
      m_acc = in_valid && !m_pkt_pend && !m_tx_pend;
      m_rst = 0;
      if (m_pkt_pend && pkt_ready) m_pkt_pend = 0;
      if (m_tx_pend && tx_ready) begin
        m_tx_pend = 0; m_err_t = 0; m_err_u = 0;
      end
      if (m_collect) begin
        if (m_acc) begin
          m_bytes.push_back(in_data);
          m_gap = 0;
          if (m_bytes.size() == NB) begin
            m_collect = 0; m_pkt_pend = 1; m_pkt_op = 8'h10; m_pkt_pay = '0;
            for (int k = 0; k < NB; k++) m_pkt_pay[8*k +: 8] = m_bytes[k];
          end
        end else begin
          m_gap++;
          if (m_gap == T) begin
            m_collect = 0; m_err_t = 1;
          end
        end
      end else if (m_acc) begin
        case (in_data)
          8'h00: ;
          8'h01: m_rst = 1;
          8'h02: begin m_tx_pend = 1; m_tx_byte = 8'hA5; end
          8'h03: begin m_tx_pend = 1; m_tx_byte = {6'b0, m_err_t, m_err_u}; end
          8'h10: begin m_collect = 1; m_gap = 0; m_bytes.delete(); end
          8'h20, 8'h21: begin m_pkt_pend = 1; m_pkt_op = in_data; m_pkt_pay = '0; end
          default: m_err_u = 1;
        endcase
      end
    end
  end

  // ---------------- compare + monitor (falling edge) ----------------
  logic [7:0]    op_log[$];
  logic [PW-1:0] pay_log[$];
  logic [7:0]    tx_log[$];
  int            pv_cycles  = 0;
  int            rst_cycles = 0;

  always @(negedge clk_system) begin
    if (!rstn_system) begin
      check("rst_in_ready",    in_ready, 1);
      check("rst_pkt_valid",   pkt_valid, 0);
      check("rst_pkt_opcode",  pkt_opcode, 0);
      check("rst_pkt_payload", pkt_payload, 0);
      check("rst_tx_valid",    tx_valid, 0);
      check("rst_tx_data",     tx_data, 0);
      check("rst_cmd_reset",   cmd_reset, 0);
      check("rst_err_flags",   err_flags, 0);
    end else begin
      check("in_ready",  in_ready,  !(m_pkt_pend || m_tx_pend));
      check("pkt_valid", pkt_valid, m_pkt_pend);
      check("tx_valid",  tx_valid,  m_tx_pend);
      check("cmd_reset", cmd_reset, m_rst);
      check("err_flags", err_flags, {m_err_t, m_err_u});
      if (m_pkt_pend) begin
        check("pkt_opcode",  pkt_opcode,  m_pkt_op);
        check("pkt_payload", pkt_payload, m_pkt_pay);
      end
      if (m_tx_pend) check("tx_data", tx_data, m_tx_byte);
      if (pkt_valid) pv_cycles++;
      if (cmd_reset) rst_cycles++;
      if (pkt_valid && pkt_ready) begin
        op_log.push_back(pkt_opcode);
        pay_log.push_back(pkt_payload);
      end
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    end
  end

  // ---------------- ready drivers ----------------
  bit rand_rdy = 0;
  bit fix_pr   = 1;
  bit fix_tr   = 1;

  initial begin
    forever begin
      @(posedge clk_system);
      #1;
      if (rand_rdy) begin
        pkt_ready = 1'($urandom_range(0, 1));
        tx_ready  = 1'($urandom_range(0, 1));
      end else begin
        pkt_ready = fix_pr;
        tx_ready  = fix_tr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_system);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_system);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk_system);
    #1;
    in_valid = 1'b0;
    check("byte_accepted", ok, 1);
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_system);
      if (!pkt_valid && !tx_valid) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk_system);
    #1;
    check("outputs_drained", ok, 1);
  endtask

  task automatic clear_logs();
    op_log.delete();
    pay_log.delete();
    tx_log.delete();
    pv_cycles  = 0;
    rst_cycles = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [PW-1:0] exp_pay;
  logic [7:0]    tri_bytes[NB];
  logic [7:0]    op;

  initial begin
    #1 rstn_system = 1'b0;
    idle(3);
    #2 rstn_system = 1'b1;
    idle(2);

    // Triangle with bytes 1..18, always-ready pipeline.
    fix_pr = 1; fix_tr = 1;
    idle(2);
    clear_logs();
    send_byte(8'h10);
    for (int k = 0; k < NB; k++) send_byte(8'(k + 1));
    wait_quiet();
    idle(2);
    exp_pay = '0;
    for (int k = 0; k < NB; k++) exp_pay[8*k +: 8] = 8'(k + 1);
    check("t1_pkt_count", op_log.size(), 1);
    check("t1_valid_cycles", pv_cycles, 1);
    if (op_log.size() >= 1) begin
      check("t1_opcode", op_log[0], 8'h10);
      check("t1_payload", pay_log[0], exp_pay);
    end

    // BEGIN_FRAME held by back-pressure, END_FRAME queued behind it.
    fix_pr = 0;
    idle(2);
    clear_logs();
    send_byte(8'h20);
    in_valid = 1'b1;
    in_data  = 8'h21;
    idle(10);
    check("t2_stall_in_ready", in_ready, 0);
    check("t2_stall_no_pkt", op_log.size(), 0);
    fix_pr = 1;
    send_byte(8'h21);
    wait_quiet();
    idle(2);
    check("t2_pkt_count", op_log.size(), 2);
    if (op_log.size() >= 2) begin
      check("t2_op0", op_log[0], 8'h20);
      check("t2_pay0", pay_log[0], 0);
      check("t2_op1", op_log[1], 8'h21);
      check("t2_pay1", pay_log[1], 0);
    end

    // Payload stalls past the timeout.
    clear_logs();
    send_byte(8'h10);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)));
    idle(T + 10);
    check("t3_err_timeout", err_flags, 2'b10);
    check("t3_no_pkt", op_log.size(), 0);
    send_byte(8'h20);
    wait_quiet();
    idle(2);
    check("t3_after_count", op_log.size(), 1);
    if (op_log.size() >= 1) check("t3_after_op", op_log[0], 8'h20);

    // STATUS reads the timeout flag and clears it.
    clear_logs();
    send_byte(8'h03);
    wait_quiet();
    idle(2);
    check("t3_status_count", tx_log.size(), 1);
    if (tx_log.size() >= 1) check("t3_status_reply", tx_log[0], 8'h02);
    check("t3_status_cleared", err_flags, 2'b00);

    // Unknown opcode then two STATUS reads.
    clear_logs();
    send_byte(8'h7F);
    idle(1);
    check("t4_err_unknown", err_flags, 2'b01);
    send_byte(8'h03);
    wait_quiet();
    idle(2);
    check("t4_err_cleared", err_flags, 2'b00);
    send_byte(8'h03);
    wait_quiet();
    idle(2);
    check("t4_reply_count", tx_log.size(), 2);
    if (tx_log.size() >= 2) begin
      check("t4_reply0", tx_log[0], 8'h01);
      check("t4_reply1", tx_log[1], 8'h00);
    end

    // PING then RESET.
    clear_logs();
    send_byte(8'h02);
    send_byte(8'h01);
    wait_quiet();
    idle(3);
    check("t5_reply_count", tx_log.size(), 1);
    if (tx_log.size() >= 1) check("t5_ping_reply", tx_log[0], 8'hA5);
    check("t5_reset_cycles", rst_cycles, 1);
    check("t5_no_pkt", op_log.size(), 0);

    // Reset in the middle of a triangle payload, then a full triangle.
    send_byte(8'h10);
    for (int k = 0; k < 7; k++) send_byte(8'($urandom_range(0, 255)));
    #2 rstn_system = 1'b0;
    idle(3);
    #2 rstn_system = 1'b1;
    idle(2);
    clear_logs();
    exp_pay = '0;
    for (int k = 0; k < NB; k++) begin
      tri_bytes[k] = 8'($urandom_range(0, 255));
      exp_pay[8*k +: 8] = tri_bytes[k];
    end
    send_byte(8'h10);
    for (int k = 0; k < NB; k++) send_byte(tri_bytes[k]);
    wait_quiet();
    idle(2);
    check("t6_pkt_count", op_log.size(), 1);
    if (op_log.size() >= 1) begin
      check("t6_opcode", op_log[0], 8'h10);
      check("t6_payload", pay_log[0], exp_pay);
    end

    // Random command traffic with random back-pressure.
    rand_rdy = 1;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 9))
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = 8'h02;
        3: op = 8'h03;
        4, 5: op = 8'h10;
        6: op = 8'h20;
        7: op = 8'h21;
        default: op = 8'($urandom_range(8'h22, 8'hFF));
      endcase
      send_byte(op);
      if (op == 8'h10) begin
        for (int k = 0; k < NB; k++) begin
          send_byte(8'($urandom_range(0, 255)));
          idle($urandom_range(0, 2));
        end
      end
      idle($urandom_range(0, 2));
    end
    rand_rdy = 0;
    fix_pr   = 1;
    fix_tr   = 1;
    idle(2);
    wait_quiet();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog elapsed t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
